// File: rtl/gearbox_pkg.sv
// Shared types and constants for the gearbox shift front end.
package gearbox_pkg;

    localparam int unsigned GEAR_W = 3;

    typedef logic [GEAR_W-1:0] gear_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        LOCK = 2'd2
    } shift_state_t;

    localparam gear_t GEAR_MIN = GEAR_W'(1);

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/shift_debouncer.sv
// Two-flop synchroniser, counter debounce and registered rising-edge pulse
// for one raw push button.
module shift_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // Synchronise, count disagreement with the clean level, flip once it persists.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            rise  <= 1'b0;
            if (sync2 != level) begin
                if (cnt == CW'(DEBOUNCE_CYCLES)) begin
                    level <= sync2;
                    cnt   <= '0;
                    rise  <= sync2;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/gear_shift_conditioner.sv
// Gear shift conditioner: debounces up/down buttons, range-checks presses
// against the current gear and issues one shift request per accepted press,
// followed by a lockout window.
// Optional feature macro: SHIFT_AUTOREPEAT_EN (auto-repeat of a held button).
module gear_shift_conditioner
    import gearbox_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned LOCKOUT_CYCLES  = 64,
    parameter int unsigned MAX_GEAR        = 5,
    parameter int unsigned REPEAT_CYCLES   = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       up_raw_i,
    input  logic       down_raw_i,
    input  logic [2:0] gear_i,
    output logic       shift_valid_o,
    output logic       shift_dir_o,
    input  logic       shift_ready_i,
    output logic       reject_o,
    output logic       lockout_o
);

    localparam int unsigned LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    // Parameter sanity checks at elaboration.
    if (DEBOUNCE_CYCLES < 1) begin : g_chk_deb
        $error("DEBOUNCE_CYCLES must be >= 1");
    end
    if (LOCKOUT_CYCLES < 1) begin : g_chk_lock
        $error("LOCKOUT_CYCLES must be >= 1");
    end
    if (REPEAT_CYCLES < 1) begin : g_chk_rep
        $error("REPEAT_CYCLES must be >= 1");
    end

    shift_state_t  state;
    shift_state_t  state_next;
    logic          dir_q;
    logic          dir_n;
    logic          reject_q;
    logic          reject_c;
    logic [LW-1:0] lock_cnt;

    logic          up_level;
    logic          up_rise;
    logic          down_level;
    logic          down_rise;
    logic          up_ev;
    logic          down_ev;

    shift_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up_deb (
        .clk   (clk),
        .rst   (rst),
        .raw   (up_raw_i),
        .level (up_level),
        .rise  (up_rise)
    );

    shift_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down_deb (
        .clk   (clk),
        .rst   (rst),
        .raw   (down_raw_i),
        .level (down_level),
        .rise  (down_rise)
    );

`ifdef SHIFT_AUTOREPEAT_EN
    localparam int unsigned RW = $clog2(REPEAT_CYCLES + 1);

    logic [RW-1:0] rep_cnt;
    logic          rep_fire;

    assign rep_fire = (state == IDLE) && (up_level || down_level) &&
                      (rep_cnt == RW'(REPEAT_CYCLES - 1));

    // Count IDLE cycles with a held button; restart on any press or state exit.
    always_ff @(posedge clk) begin
        if (rst || (state != IDLE) || !(up_level || down_level) ||
            rep_fire || up_rise || down_rise) begin
            rep_cnt <= '0;
        end else begin
            rep_cnt <= rep_cnt + RW'(1);
        end
    end

    assign up_ev   = up_rise   || (rep_fire && up_level);
    assign down_ev = down_rise || (rep_fire && down_level);
`else
    assign up_ev   = up_rise;
    assign down_ev = down_rise;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, direction capture and reject decision.
    always_comb begin
        state_next = state;
        dir_n      = dir_q;
        reject_c   = 1'b0;
        unique case (state)
            IDLE: begin
                if (up_ev && down_ev) begin
                    reject_c = 1'b1;
                end else if (up_ev) begin
                    if (gear_i < GEAR_W'(MAX_GEAR)) begin
                        state_next = REQ;
                        dir_n      = DIR_UP;
                    end else begin
                        reject_c = 1'b1;
                    end
                end else if (down_ev) begin
                    if (gear_i > GEAR_MIN) begin
                        state_next = REQ;
                        dir_n      = DIR_DOWN;
                    end else begin
                        reject_c = 1'b1;
                    end
                end
            end
            REQ: begin
                reject_c = up_ev || down_ev;
                if (shift_ready_i) begin
                    state_next = LOCK;
                end
            end
            LOCK: begin
                reject_c = up_ev || down_ev;
                if (lock_cnt == '0) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Direction, lockout counter and reject pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            dir_q    <= 1'b0;
            lock_cnt <= '0;
            reject_q <= 1'b0;
        end else begin
            reject_q <= reject_c;
            if ((state == IDLE) && (state_next == REQ)) begin
                dir_q <= dir_n;
            end
            if ((state == REQ) && (state_next == LOCK)) begin
                lock_cnt <= LW'(LOCKOUT_CYCLES - 1);
            end else if ((state == LOCK) && (lock_cnt != '0)) begin
                lock_cnt <= lock_cnt - LW'(1);
            end
        end
    end

    // Outputs decoded from registered state.
    always_comb begin
        shift_valid_o = (state == REQ);
        lockout_o     = (state == LOCK);
        shift_dir_o   = dir_q;
        reject_o      = reject_q;
    end

endmodule
